uart_receiver: RTL and testbench

//   Receive half of the pinacolada UART; pairs with uart_transmitter on the same line format.

---
 rtl/uart_receiver_pkg.sv | 19 +
 rtl/uart_rx_sync.sv | 25 ++
 rtl/uart_receiver.sv | 125 ++++++++++++
 tb/tb_uart_receiver.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_receiver_pkg.sv
// rtl/uart_receiver_pkg.sv - shared UART line-format constants and receiver state type
package uart_receiver_pkg;

  localparam int UART_CLKS_PER_BIT = 434;
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_RECOVER = 3'd4
  } rx_state_e;

  function automatic int half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for an idle-high asynchronous input pin
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  // Reset to 1 so an idle-high line never looks like a start edge coming out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with mid-bit sampling and framing-error detection
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_done,
  output logic       rx_error,
  output logic       rx_busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(half_bit(CLKS_PER_BIT) - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(UART_DATA_BITS - 1);

  logic       rx_s;
  rx_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] byte_q, byte_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (rx),
    .sync_o  (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      // Re-check the line at mid start bit so short glitches are dropped silently.
      ST_START: begin
        if (cnt_q == CNT_HALF_END) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_BIT_END) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == IDX_LAST) state_d = ST_STOP;
          else                   idx_d   = idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // Leaving at mid stop bit leaves half a bit of margin to catch the next start edge.
      ST_STOP: begin
        if (cnt_q == CNT_BIT_END) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_d  = shift_q;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_RECOVER;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RECOVER: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rx_byte  = byte_q;
  assign rx_done  = done_q;
  assign rx_error = err_q;
  assign rx_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver against a frame-level model
module tb_uart_receiver;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + 1 + HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_done;
  logic       rx_error;
  logic       rx_busy;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_byte  (rx_byte),
    .rx_done  (rx_done),
    .rx_error (rx_error),
    .rx_busy  (rx_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int   cyc = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   busy_cnt = 0;
  int   overlap_cnt = 0;
  int   long_cnt = 0;
  logic prev_done = 1'b0;
  logic prev_err = 1'b0;
  logic [7:0] got_q[$];
  int         got_t[$];
  int         start_cyc = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rx_done) begin
      done_cnt = done_cnt + 1;
      got_q.push_back(rx_byte);
      got_t.push_back(cyc);
    end
    if (rx_error) err_cnt = err_cnt + 1;
    if (rx_busy) busy_cnt = busy_cnt + 1;
    if (rx_done && rx_error) overlap_cnt = overlap_cnt + 1;
    if ((rx_done && prev_done) || (rx_error && prev_err)) long_cnt = long_cnt + 1;
    prev_done = rx_done;
    prev_err  = rx_error;
  end

  task automatic hold(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Frame edges at k*CPB + jitter_k (jitter within +-jit), start and end edges on grid.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int jit);
    logic [9:0] bits;
    int         off[11];
    bits = {stop_bit, data, 1'b0};
    off[0]  = 0;
    off[10] = 0;
    for (int k = 1; k < 10; k++)
      off[k] = (jit == 0) ? 0 : $urandom_range(2 * jit, 0) - jit;
    start_cyc = cyc;
    for (int k = 0; k < 10; k++)
      hold(bits[k], CPB + off[k+1] - off[k]);
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    if ({rx_byte, rx_done, rx_error, rx_busy} !== 11'h000) begin
      $display("FAIL reset_outputs: got byte=%h done=%b err=%b busy=%b, want 00/0/0/0",
               rx_byte, rx_done, rx_error, rx_busy);
      n_fail++;
    end
    n_checks++;
    rst = 1'b0;
    hold(1'b1, 4);
  endtask

  task automatic test_single();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h41, 1'b1, 0);
    hold(1'b1, 2 * CPB);
    if (done_cnt - d0 != 1) begin
      $display("FAIL single_done_count: got %0d, want 1", done_cnt - d0); n_fail++;
    end
    n_checks++;
    if (rx_byte !== 8'h41) begin
      $display("FAIL single_byte: got %h, want 41", rx_byte); n_fail++;
    end
    n_checks++;
    if (err_cnt != e0) begin
      $display("FAIL single_no_error: got %0d errors, want 0", err_cnt - e0); n_fail++;
    end
    n_checks++;
    if (got_t.size() == 0 || got_t[$] - start_cyc < LAT - 2 || got_t[$] - start_cyc > LAT + 2) begin
      $display("FAIL single_latency: got %0d, want %0d +-2",
               (got_t.size() == 0) ? -1 : got_t[$] - start_cyc, LAT); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_glitch();
    int d0, e0, b0;
    d0 = done_cnt; e0 = err_cnt; b0 = busy_cnt;
    hold(1'b0, 4);
    hold(1'b1, 2 * CPB);
    if (busy_cnt == b0) begin
      $display("FAIL glitch_busy: got 0 busy cycles, want >0"); n_fail++;
    end
    n_checks++;
    if (rx_busy !== 1'b0 || done_cnt != d0 || err_cnt != e0) begin
      $display("FAIL glitch_quiet: got busy=%b dones=%0d errs=%0d, want 0/0/0",
               rx_busy, done_cnt - d0, err_cnt - e0); n_fail++;
    end
    n_checks++;
    if (rx_byte !== 8'h41) begin
      $display("FAIL glitch_byte: got %h, want 41", rx_byte); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_framing_error();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h55, 1'b0, 0);
    hold(1'b0, 3 * CPB);
    if (rx_busy !== 1'b1) begin
      $display("FAIL break_busy: got %b, want 1", rx_busy); n_fail++;
    end
    n_checks++;
    hold(1'b1, 2 * CPB);
    if (err_cnt - e0 != 1 || done_cnt != d0) begin
      $display("FAIL frame_err_pulses: got errs=%0d dones=%0d, want 1/0",
               err_cnt - e0, done_cnt - d0); n_fail++;
    end
    n_checks++;
    if (rx_byte !== 8'h41 || rx_busy !== 1'b0) begin
      $display("FAIL frame_err_hold: got byte=%h busy=%b, want 41/0", rx_byte, rx_busy); n_fail++;
    end
    n_checks++;
    send_frame(8'h3C, 1'b1, 0);
    hold(1'b1, 2 * CPB);
    if (rx_byte !== 8'h3C || done_cnt - d0 != 1) begin
      $display("FAIL after_error_byte: got byte=%h dones=%0d, want 3c/1", rx_byte, done_cnt - d0);
      n_fail++;
    end
    n_checks++;
  endtask

  // Model: each well-formed frame yields exactly its data byte, in order.
  task automatic check_stream(input string name, input logic [7:0] exp_q[$], input int base);
    if (got_q.size() - base != exp_q.size()) begin
      $display("FAIL %s_count: got %0d, want %0d", name, got_q.size() - base, exp_q.size());
      n_fail++;
    end
    n_checks++;
    foreach (exp_q[i]) begin
      if (base + i < got_q.size()) begin
        if (got_q[base + i] !== exp_q[i]) begin
          $display("FAIL %s_byte%0d: got %h, want %h", name, i, got_q[base + i], exp_q[i]);
          n_fail++;
        end
        n_checks++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    int base, e0;
    base = got_q.size(); e0 = err_cnt;
    exp_q = '{8'h00, 8'hFF, 8'hA5};
    for (int i = 0; i < 5; i++) exp_q.push_back(8'($urandom));
    foreach (exp_q[i]) send_frame(exp_q[i], 1'b1, 0);
    hold(1'b1, 2 * CPB);
    check_stream("b2b", exp_q, base);
    if (err_cnt != e0) begin
      $display("FAIL b2b_no_error: got %0d, want 0", err_cnt - e0); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] bits;
    int d0, e0;
    bits = {1'b1, 8'h99, 1'b0};
    for (int k = 0; k < 5; k++) hold(bits[k], CPB);
    hold(bits[5], HALF);
    #2 rst = 1'b1;
    #1;
    if ({rx_byte, rx_done, rx_error, rx_busy} !== 11'h000) begin
      $display("FAIL async_reset: got byte=%h done=%b err=%b busy=%b, want 00/0/0/0",
               rx_byte, rx_done, rx_error, rx_busy); n_fail++;
    end
    n_checks++;
    d0 = done_cnt; e0 = err_cnt;
    rx = 1'b1;
    @(negedge clk); #1;
    hold(1'b1, 5);
    rst = 1'b0;
    hold(1'b1, 3 * CPB);
    if (done_cnt != d0 || err_cnt != e0) begin
      $display("FAIL reset_no_pulse: got dones=%0d errs=%0d, want 0/0",
               done_cnt - d0, err_cnt - e0); n_fail++;
    end
    n_checks++;
    send_frame(8'h12, 1'b1, 0);
    hold(1'b1, 2 * CPB);
    if (rx_byte !== 8'h12 || done_cnt - d0 != 1) begin
      $display("FAIL reset_then_byte: got byte=%h dones=%0d, want 12/1", rx_byte, done_cnt - d0);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_jitter();
    logic [7:0] exp_q[$];
    int base, e0;
    base = got_q.size(); e0 = err_cnt;
    exp_q = '{8'hC3};
    send_frame(8'hC3, 1'b1, 3);
    hold(1'b1, 2 * CPB);
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(8'($urandom));
      send_frame(exp_q[$], 1'b1, 3);
      hold(1'b1, $urandom_range(20, 0) + 1);
    end
    hold(1'b1, 2 * CPB);
    check_stream("jitter", exp_q, base);
    if (err_cnt != e0) begin
      $display("FAIL jitter_no_error: got %0d, want 0", err_cnt - e0); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_pulse_shape();
    if (overlap_cnt != 0 || long_cnt != 0) begin
      $display("FAIL pulse_shape: got overlap=%0d long=%0d, want 0/0", overlap_cnt, long_cnt);
      n_fail++;
    end
    n_checks++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_framing_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_jitter();
    test_pulse_shape();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
